// File: rtl/ped_pkg.sv
// Shared constants for the pedestrian-request block: light encodings and
// default sizing parameters used by the request latch and its debouncers.
package ped_pkg;

  // Light colour encodings as driven on a signal head (one-hot).
  typedef enum logic [2:0] {
    LIGHT_RED   = 3'b100,
    LIGHT_AMBER = 3'b010,
    LIGHT_GREEN = 3'b001
  } light_e;

  // Default sizing for the request latch.
  localparam int unsigned N_BTN_DEF      = 10;
  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned MAX_WAIT_DEF   = 30;

  // Width of a counter that must hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter and a
// registered one-clk pulse on every accepted 0->1 transition of the level.
module btn_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,      // synchronous, active-low
  input  logic btn_i,    // raw asynchronous level, 1 = pressed
  output logic rise_o    // one-clk pulse after the debounced level rises
);

  // The counter only has to reach DEB_CYCLES-1; the accepting sample is
  // the one that finds it already there.
  localparam int unsigned  CNT_W    = cnt_width(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Two-flop synchroniser; nothing else looks at the raw button.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and the registered edge pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ped_request_latch.sv
// Pedestrian request latch: debounces N_BTN push-buttons, latches a request
// per button until the controller serves that light, ages each pending
// request in ticks and drives blinking / steady WAIT lamps.
module ped_request_latch
  import ped_pkg::*;
#(
  parameter int unsigned N_BTN      = N_BTN_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             tick,       // one-clk timebase pulse
  input  logic [N_BTN-1:0] btn,        // raw button levels
  input  logic [N_BTN-1:0] serve,      // light i+1 currently green
  output logic [N_BTN-1:0] req,
  output logic             req_any,
  output logic [N_BTN-1:0] wait_lamp,
  output logic             urgent
);

  localparam int unsigned     WAIT_W   = cnt_width(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  req_q,   req_d;
  logic [N_BTN-1:0]  lamp_q,  lamp_d;
  logic              any_q,   any_d;
  logic              urg_q,   urg_d;
  logic              blink_q, blink_d;
  logic [WAIT_W-1:0] wcnt_q [N_BTN];
  logic [WAIT_W-1:0] wcnt_d [N_BTN];

  // One debouncer per button.
  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn[g]),
      .rise_o (rise[g])
    );
  end

  // Request, ageing, blink and lamp next-state. Serve overrides a press
  // arriving on the same clk; the lamp is computed from next-state values
  // so it lines up with req, blink and urgent on the same clk.
  always_comb begin
    req_d   = (req_q | rise) & ~serve;
    any_d   = |req_q;
    blink_d = tick ? ~blink_q : blink_q;
    urg_d   = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      wcnt_d[i] = wcnt_q[i];
      if (!req_q[i]) begin
        wcnt_d[i] = '0;
      end else if (tick && (wcnt_q[i] != WAIT_MAX)) begin
        wcnt_d[i] = wcnt_q[i] + 1'b1;
      end
      if (wcnt_q[i] == WAIT_MAX) begin
        urg_d = 1'b1;
      end
    end
    lamp_d = urg_d ? req_d : (req_d & {N_BTN{blink_d}});
  end

  // Output and ageing registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q   <= '0;
      lamp_q  <= '0;
      any_q   <= 1'b0;
      urg_q   <= 1'b0;
      blink_q <= 1'b0;
      // NOTE: the wait counters are plain flops, not a RAM, and must start
      // from zero after reset, so the whole array is cleared here.
      for (int i = 0; i < N_BTN; i++) begin
        wcnt_q[i] <= '0;
      end
    end else begin
      req_q   <= req_d;
      lamp_q  <= lamp_d;
      any_q   <= any_d;
      urg_q   <= urg_d;
      blink_q <= blink_d;
      for (int i = 0; i < N_BTN; i++) begin
        wcnt_q[i] <= wcnt_d[i];
      end
    end
  end

  assign req       = req_q;
  assign req_any   = any_q;
  assign wait_lamp = lamp_q;
  assign urgent    = urg_q;

endmodule

// File: tb/tb_ped_request_latch.sv
// Directed bench for ped_request_latch with default parameters
// (10 buttons, 4-sample debounce, 30-tick urgency).
module tb_ped_request_latch;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [N-1:0] btn;
  logic [N-1:0] serve;
  logic [N-1:0] req;
  logic         req_any;
  logic [N-1:0] wait_lamp;
  logic         urgent;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_blink;

  ped_request_latch dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn       (btn),
    .serve     (serve),
    .req       (req),
    .req_any   (req_any),
    .wait_lamp (wait_lamp),
    .urgent    (urgent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns on a falling edge, where outputs are
  // sampled and inputs are driven.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    exp_blink = ~exp_blink;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; btn = '0; serve = '0; exp_blink = 1'b0;
    cyc(2);
    check("rst_req",     32'(req),       0);
    check("rst_any",     32'(req_any),   0);
    check("rst_lamp",    32'(wait_lamp), 0);
    check("rst_urgent",  32'(urgent),    0);
    rst = 1'b1;
    cyc(2);

    // Press latency: 2 sync + 4 debounce + 1 latch = 7 clk.
    btn[2] = 1'b1;
    cyc(6);
    check("lat_req2_at6", 32'(req[2]), 0);
    cyc(1);
    check("lat_req2_at7", 32'(req[2]), 1);
    check("lat_any_at7",  32'(req_any), 0);
    check("lat_lamp2",    32'(wait_lamp[2]), 0);  // blink is 0
    cyc(1);
    check("lat_any_at8",  32'(req_any), 1);
    cyc(2);
    btn[2] = 1'b0;
    serve[2] = 1'b1; cyc(1); serve[2] = 1'b0;
    check("serve_req2", 32'(req), 0);
    cyc(8);

    // Bouncy press: 1,1,0 pattern never gives 4 stable samples.
    for (int r = 0; r < 7; r++) begin
      btn[0] = 1'b1; cyc(2);
      btn[0] = 1'b0; cyc(1);
    end
    check("bounce_req0", 32'(req[0]), 0);
    cyc(8);
    check("bounce_req0_after", 32'(req), 0);

    // Serve clears req and lamp; held button does not re-latch.
    btn[4] = 1'b1;
    cyc(7);
    check("srv_req4_set", 32'(req[4]), 1);
    do_tick();
    check("srv_lamp4_on", 32'(wait_lamp[4]), 1);
    serve[4] = 1'b1; cyc(1); serve[4] = 1'b0;
    check("srv_req4_clr",  32'(req[4]), 0);
    check("srv_lamp4_clr", 32'(wait_lamp[4]), 0);
    cyc(20);
    check("srv_held_noset", 32'(req), 0);
    btn[4] = 1'b0;
    cyc(8);

    // Debounced edge coinciding with serve: serve wins.
    btn[3] = 1'b1;
    cyc(6);
    serve[3] = 1'b1; cyc(1); serve[3] = 1'b0;
    check("race_req3", 32'(req[3]), 0);
    cyc(5);
    check("race_req3_later", 32'(req), 0);
    btn[3] = 1'b0;
    cyc(8);

    // Ageing: blink toggles each tick until tick 30, then steady + urgent.
    btn[1] = 1'b1;
    cyc(7);
    check("age_req1", 32'(req[1]), 1);
    btn[1] = 1'b0;
    check("age_lamp_pre", 32'(wait_lamp[1]), 32'(exp_blink));
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      check($sformatf("age_lamp_t%0d", k), 32'(wait_lamp[1]),
            32'(exp_blink));
      if (k >= 29) check($sformatf("age_urg_t%0d", k), 32'(urgent), 0);
      cyc(1);
    end
    check("age_urgent",     32'(urgent), 1);
    check("age_lamp_steady", 32'(wait_lamp[1]), 1);
    for (int k = 0; k < 2; k++) begin
      do_tick();
      cyc(1);
      check($sformatf("age_sat_lamp%0d", k), 32'(wait_lamp[1]), 1);
      check($sformatf("age_sat_urg%0d", k),  32'(urgent), 1);
    end
    serve[1] = 1'b1; cyc(1); serve[1] = 1'b0;
    check("age_srv_req",  32'(req[1]), 0);
    check("age_srv_lamp", 32'(wait_lamp[1]), 0);
    cyc(2);
    check("age_srv_urg",  32'(urgent), 0);
    cyc(4);

    // Reset mid-wait discards the request; held button re-registers.
    btn[5] = 1'b1;
    cyc(7);
    check("rw_req5_set", 32'(req[5]), 1);
    for (int k = 0; k < 12; k++) begin
      do_tick();
      cyc(1);
    end
    check("rw_urg_pre", 32'(urgent), 0);
    rst = 1'b0; cyc(1); rst = 1'b1;
    exp_blink = 1'b0;
    check("rw_req",    32'(req),       0);
    check("rw_any",    32'(req_any),   0);
    check("rw_lamp",   32'(wait_lamp), 0);
    check("rw_urgent", 32'(urgent),    0);
    cyc(6);
    check("rw_req5_at6", 32'(req), 0);
    cyc(1);
    check("rw_req5_at7", 32'(req), 32'h020);
    btn[5] = 1'b0;
    serve = '1; cyc(1); serve = '0;
    cyc(8);

    // All buttons on the same clk latch on the same clk.
    btn = '1;
    cyc(6);
    check("all_at6", 32'(req), 0);
    cyc(1);
    check("all_at7", 32'(req), 32'h3FF);
    cyc(1);
    check("all_any", 32'(req_any), 1);
    serve = '1; cyc(1); serve = '0;
    check("all_srv", 32'(req), 0);
    btn = '0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ped_request_latch.md
PED_REQUEST_LATCH -- requirements
Module: ped_request_latch

Interface
REQ-001 Parameter N_BTN, default 10, SHALL be the number of pedestrian push-buttons; button i maps to pedestrian light P(i+1).
REQ-002 Parameter DEB_CYCLES, default 4, SHALL be the number of consecutive stable clk samples needed to accept a button level.
REQ-003 Parameter MAX_WAIT, default 30, SHALL be the number of tick pulses after which a pending request is flagged urgent.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-006 tick  input  1  SHALL be a one-clk-wide timebase pulse, nominally 1 Hz.
REQ-007 btn  input  N_BTN  SHALL be the raw asynchronous button levels, 1 = pressed.
REQ-008 serve  input  N_BTN  SHALL be set per bit while the controller drives that pedestrian light green (3'b001).
REQ-009 req  output  N_BTN  SHALL be the latched pending pedestrian requests, registered.
REQ-010 req_any  output  1  SHALL be the OR of req, registered.
REQ-011 wait_lamp  output  N_BTN  SHALL drive the "WAIT" indicators, registered.
REQ-012 urgent  output  1  SHALL be set while any request has waited MAX_WAIT or more ticks, registered.

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-014 The debounced level SHALL change only after DEB_CYCLES consecutive synchronised samples differ from it; any sample equal to the current level SHALL restart that count.
REQ-015 A request SHALL be set on the clk after a debounced 0->1 edge; held presses and further edges while set SHALL have no effect.
REQ-016 A set request SHALL clear on the first clk where its serve bit is 1.
REQ-017 If a debounced edge and serve=1 occur on the same clk for the same bit, req SHALL stay or become 0 (serve wins).
REQ-018 While serve is 1, new presses on that bit SHALL be ignored; a press still held after serve falls SHALL NOT set req without a fresh debounced 0->1 edge.
REQ-019 Each bit SHALL have a wait counter: cleared when req is 0, incremented on tick while req is 1, saturating at MAX_WAIT.
REQ-020 urgent SHALL be 1 when any counter equals MAX_WAIT, appearing on the clk after the saturating tick.
REQ-021 A per-block blink flop SHALL toggle on every tick; wait_lamp[i] SHALL equal req[i] AND blink when urgent is 0, and req[i] (steady) when urgent is 1.
REQ-022 Latency from debounced edge to req SHALL be 1 clk; press to req SHALL be 2 + DEB_CYCLES + 1 clk.
REQ-023 Pressing all buttons on the same clk SHALL set all requests on the same clk.

Reset
REQ-024 With rst=0 at a clk edge, req, req_any, wait_lamp, urgent, blink, counters and synchronisers SHALL be 0, and debounced levels SHALL be 0 (released).
REQ-025 Reset asserted mid-debounce or mid-wait SHALL discard all pending requests; a button held through reset release SHALL register as a new press once debounced.

Structure
REQ-026 Shared package ped_pkg SHALL hold the light encodings (red 3'b100, amber 3'b010, green 3'b001) and the default values of N_BTN, DEB_CYCLES and MAX_WAIT.
REQ-027 Debounce SHALL be a sub-module btn_debounce (sync + counter + edge pulse), instantiated N_BTN times.
REQ-028 Counter widths SHALL be derived with $clog2 from DEB_CYCLES and MAX_WAIT.

Verification
REQ-029 Press btn[2] for 10 clk, serve=0 -> req[2]=1 exactly 7 clk after the press starts; req_any=1 one clk later.
REQ-030 Press btn[0] with a 1-clk gap inside every 3 clk for 20 clk -> req[0] stays 0.
REQ-031 Latch req[4], then serve[4]=1 for 1 clk -> req[4]=0 and wait_lamp[4]=0 on the next clk; a button held through this does not re-set req[4].
REQ-032 Latch req[1], apply 30 ticks -> urgent=1 and wait_lamp[1] steady 1; before tick 30, wait_lamp[1] toggles each tick.
REQ-033 Debounced edge on bit 3 on the same clk as serve[3]=1 -> req[3] remains 0.
REQ-034 Latch req[5] with counter at 12, pulse rst=0 for 1 clk -> all outputs 0; with btn[5] still held, req[5]=1 after debounce.
